usart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the USART receiver. The receiver reports each completed byte by holding it on a data bus and flipping a toggle line. This block detects each toggle, captures the byte into a DEPTH-entry FIFO, and presents bytes to the consumer over a valid/ready stream. It reports fill level and a sticky overflow flag, so bytes are never lost silently when the consumer stalls.

---
 rtl/usart_pkg.sv | 21 ++
 rtl/usart_byte_fifo.sv | 114 +++++++++++
 rtl/usart_rx_fifo.sv | 103 ++++++++++
 tb/tb_usart_rx_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// ---------------------------------------------------------------------------
// usart_pkg
//   Shared constants and types for the USART blocks (receiver, transmitter
//   and their byte buffers).
//   - USART_CLK_FREQ / USART_BAUD_RATE / USART_DATA_BIT : default settings
//   - USART_CLKS_PER_BIT : system clocks per serial bit time
//   - usart_byte_t       : one character at the default width
// ---------------------------------------------------------------------------
package usart_pkg;

  localparam int unsigned USART_CLK_FREQ  = 50_000_000;
  localparam int unsigned USART_BAUD_RATE = 115_200;
  localparam int unsigned USART_DATA_BIT  = 8;

  // Rounded to the nearest clock so the bit-centre sample drifts least.
  localparam int unsigned USART_CLKS_PER_BIT =
    (USART_CLK_FREQ + (USART_BAUD_RATE / 2)) / USART_BAUD_RATE;

  typedef logic [USART_DATA_BIT-1:0] usart_byte_t;

endpackage : usart_pkg

// File: rtl/usart_byte_fifo.sv
// ---------------------------------------------------------------------------
// usart_byte_fifo
//   Generic synchronous show-ahead FIFO. The head entry is held in a
//   register so rd_data is valid in the same cycle rd_valid is high.
//   A push into a full FIFO is still accepted when a pop happens in the
//   same cycle; otherwise it is dropped and reported on 'drop'.
//
//   Stream handshake: an entry moves when rd_valid && rd_ready are both
//   high at a rising clk edge. rd_valid never depends on rd_ready, and
//   rd_data is stable while rd_valid is high and rd_ready is low.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   push, wr_data     : write request and its data
//   rd_data, rd_valid : head entry and non-empty indication
//   rd_ready          : consumer takes the head entry this cycle
//   level             : occupancy, 0..DEPTH
//   full, empty       : level==DEPTH, level==0
//   drop              : push this cycle is rejected (full, no pop)
// ---------------------------------------------------------------------------
module usart_byte_fifo #(
  parameter int W      = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [W-1:0]      wr_data,
  output logic [W-1:0]      rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q,  level_d;
  logic [W-1:0]      head_q,   head_d;

  logic              pop;
  logic              push_acc;
  logic [ADDR_W-1:0] rd_next;

  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LVL);
  assign rd_valid = !empty;
  assign rd_data  = head_q;
  assign level    = level_q;

  assign pop      = rd_valid && rd_ready;
  assign push_acc = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign rd_next  = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end

    case ({push_acc, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Head register update. When the FIFO is empty after any pop, the
    // incoming byte becomes the head directly (covers the empty push and
    // the level==1 pass-through). Otherwise a pop exposes the next stored
    // entry; with level>=2 that slot is never the one being written, even
    // when full (wr_ptr==rd_ptr then, and DEPTH>=2).
    if (push_acc && (empty || (level_q == 1 && pop))) begin
      head_d = wr_data;
    end else if (pop) begin
      head_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && push_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule : usart_byte_fifo

// File: rtl/usart_rx_fifo.sv
// ---------------------------------------------------------------------------
// usart_rx_fifo
//   Receive-side byte buffer behind the USART receiver. Each level change
//   on rx_toggle marks a new byte on rx_data; the byte is captured and
//   queued, then offered to the consumer on a valid/ready stream.
//
//   Stream handshake: m_data transfers when m_valid && m_ready are high at
//   a rising clk edge; m_valid does not depend on m_ready.
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   rx_data     : byte from receiver, stable whenever rx_toggle changes
//   rx_toggle   : every level change is one new byte
//   m_data      : head byte, valid while m_valid=1
//   m_valid     : FIFO non-empty
//   m_ready     : consumer accepts m_data this cycle
//   level       : occupancy 0..DEPTH
//   full        : level==DEPTH
//   overflow    : sticky, a byte was dropped
//   ovf_clr     : clears overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int DATA_BIT = USART_DATA_BIT,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_BIT-1:0] rx_data,
  input  logic                rx_toggle,
  output logic [DATA_BIT-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADDR_W:0]     level,
  output logic                full,
  output logic                overflow,
  input  logic                ovf_clr
);

  logic                tog_q,  tog_d;
  logic                push_q, push_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                ovf_q,  ovf_d;

  logic                push_req;
  logic                fifo_empty;
  logic                fifo_drop;

  assign push_req = (rx_toggle != tog_q);
  assign overflow = ovf_q;

  // The detected edge and its byte are registered before entering the
  // FIFO; this is the single cycle of latency seen at the output.
  always_comb begin
    tog_d  = rx_toggle;
    push_d = push_req;
    data_d = push_req ? rx_data : data_q;

    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Load the live toggle level so a level present at reset is not a byte.
      tog_q  <= rx_toggle;
      push_q <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      tog_q  <= tog_d;
      push_q <= push_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  usart_byte_fifo #(
    .W      (DATA_BIT),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_q),
    .wr_data  (data_q),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .rd_ready (m_ready),
    .level    (level),
    .full     (full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

endmodule : usart_rx_fifo

// File: tb/tb_usart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_usart_rx_fifo
//   Directed bench for usart_rx_fifo. Stimulus tasks push each byte that
//   should come out into exp_q; a negedge monitor pops and compares on
//   every accepted transfer.
// ---------------------------------------------------------------------------
module tb_usart_rx_fifo;

  localparam int DATA_BIT = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [DATA_BIT-1:0] rx_data;
  logic                rx_toggle;
  logic [DATA_BIT-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic [ADDR_W:0]     level;
  logic                full;
  logic                overflow;
  logic                ovf_clr;

  logic [DATA_BIT-1:0] exp_q[$];
  int                  errors = 0;
  int                  checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  usart_rx_fifo #(
    .DATA_BIT (DATA_BIT),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_toggle (rx_toggle),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Flip the toggle with a byte; queue it if it should reach the output.
  task automatic send_byte(input logic [DATA_BIT-1:0] b, input bit expect_out);
    rx_data   = b;
    rx_toggle = ~rx_toggle;
    if (expect_out) exp_q.push_back(b);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while (m_valid && n < 64) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    check("drain_empty", {31'd0, m_valid}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL m_data_unexpected: got=0x%0h expected=none", m_data);
      end else begin
        logic [DATA_BIT-1:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL m_data_order: got=0x%0h expected=0x%0h", m_data, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    rx_data   = '0;
    rx_toggle = 1'b1;
    m_ready   = 1'b0;
    ovf_clr   = 1'b0;

    // 1: reset with toggle high, then hold it: no spurious push
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);

    // 2: single byte, one cycle latency
    send_byte(8'h14, 1'b1);
    check("lat_not_yet", {31'd0, m_valid}, 32'd0);
    tick();
    check("single_valid", {31'd0, m_valid}, 32'd1);
    check("single_data", {24'd0, m_data}, 32'h14);
    check("single_level", {27'd0, level}, 32'd1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("single_pop_valid", {31'd0, m_valid}, 32'd0);
    check("single_pop_level", {27'd0, level}, 32'd0);

    // 3: two rounds of 16 with random draining; order across pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        m_ready = 1'($urandom_range(0, 1));
        send_byte(8'(r * 16 + i), 1'b1);
      end
      m_ready = 1'b0;
      tick();
      drain();
    end

    // 4: overflow
    for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    tick();
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_level_full", {27'd0, level}, 32'd16);
    send_byte(8'hEE, 1'b0);
    tick();
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_level_kept", {27'd0, level}, 32'd16);
    drain();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // 5: full, then push 0x55 landing on the same edge as a pop
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i), 1'b1);
    tick();
    check("fp_full", {31'd0, full}, 32'd1);
    send_byte(8'h55, 1'b1);   // toggle sampled; push happens at next edge
    m_ready = 1'b1;
    tick();                   // pop and push together
    m_ready = 1'b0;
    check("fp_level", {27'd0, level}, 32'd16);
    check("fp_no_ovf", {31'd0, overflow}, 32'd0);
    drain();
    check("fp_no_ovf_end", {31'd0, overflow}, 32'd0);

    // 6: reset mid-stream discards the queued bytes
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    tick();
    check("mid_level5", {27'd0, level}, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_level", {27'd0, level}, 32'd0);
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    send_byte(8'h3C, 1'b1);
    tick();
    check("mid_first_data", {24'd0, m_data}, 32'h3C);
    drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_usart_rx_fifo
